// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Supports locked bursts, one write strobe per byte, and a busy-start watchdog.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int MAX_BURST    = 16,
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] data_flat,
    input  logic [N_REQ-1:0]   last,
    output logic [N_REQ-1:0]   ack,
    input  logic               uart_busy,
    output logic               uart_wr_enb,
    output logic [7:0]         uart_data,
    output logic               grant_valid,
    output logic [2:0]         grant_id,
    output logic               err_timeout
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_burst;
    logic [7:0] r_timer;
    logic       r_last_q;

    // Pad requester inputs to the 8-requester maximum so 3-bit indices fit exactly.
    logic [7:0]       w_req8;
    logic [7:0]       w_last8;
    logic [63:0]      w_data64;
    logic             w_found;
    logic [2:0]       w_win;
    logic [3:0]       w_j;
    logic [2:0]       w_sel;
    logic [7:0]       w_sel_data;
    logic             w_sel_last;
    logic [N_REQ-1:0] w_sel_onehot;
    logic             w_continue;

    assign w_req8   = 8'(req);
    assign w_last8  = 8'(last);
    assign w_data64 = 64'(data_flat);

    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_j     = 4'd0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_j = {1'b0, r_ptr} + 4'(i);
            if (w_j >= 4'(N_REQ))
                w_j = w_j - 4'(N_REQ);
            if (!w_found && w_req8[w_j[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_j[2:0];
            end
        end
    end

    // Capture source: the arbitration winner from IDLE, else the current owner.
    assign w_sel        = (r_state == IDLE) ? w_win : grant_id;
    assign w_sel_data   = w_data64[{w_sel, 3'b000} +: 8];
    assign w_sel_last   = w_last8[w_sel];
    assign w_sel_onehot = N_REQ'(1) << w_sel;
    assign w_continue   = !r_last_q && (r_burst < 8'(MAX_BURST)) && w_req8[grant_id];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_ptr       <= 3'(N_REQ - 1);
            r_burst     <= 8'd0;
            r_timer     <= 8'd0;
            r_last_q    <= 1'b0;
            ack         <= '0;
            uart_wr_enb <= 1'b0;
            uart_data   <= 8'd0;
            grant_valid <= 1'b0;
            grant_id    <= 3'd0;
            err_timeout <= 1'b0;
        end else begin
            ack         <= '0;
            uart_wr_enb <= 1'b0;
            err_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found && !uart_busy) begin
                        grant_valid <= 1'b1;
                        grant_id    <= w_win;
                        uart_data   <= w_sel_data;
                        r_last_q    <= w_sel_last;
                        uart_wr_enb <= 1'b1;
                        ack         <= w_sel_onehot;
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    r_burst <= r_burst + 8'd1;
                    r_timer <= 8'd0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_timer + 8'd1 == 8'(BUSY_TIMEOUT - 1)) begin
                        // Byte is dropped, not retried; the requester already saw its ack.
                        err_timeout <= 1'b1;
                        grant_valid <= 1'b0;
                        r_ptr       <= grant_id;
                        r_burst     <= 8'd0;
                        r_state     <= IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        if (w_continue) begin
                            uart_data   <= w_sel_data;
                            r_last_q    <= w_sel_last;
                            uart_wr_enb <= 1'b1;
                            ack         <= w_sel_onehot;
                            r_state     <= LOAD;
                        end else begin
                            grant_valid <= 1'b0;
                            r_ptr       <= grant_id;
                            r_burst     <= 8'd0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
